// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and default widths for the RAM request controller.
//   state_e : controller states (zero-fill, then normal command issue)
//   cmd_t   : queued command layout {wr, addr, wdata} at the default widths;
//             the controller packs its queue entries in the same field order.
package ram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_cmd_fifo.sv
// ram_cmd_fifo: synchronous FIFO holding queued RAM commands.
//   clk_i, rst_i      : clock, synchronous active-high reset (empties the queue)
//   push_i/push_data_i: enqueue request; ignored while full
//   pop_i/pop_data_o  : dequeue request; pop_data_o shows the head entry
//   full_o, empty_o   : occupancy flags
// DEPTH must be a power of two, at least 2.
module ram_cmd_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rptr_q[PTR_W-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: zero-fills a synchronous RAM after reset, then issues queued
// read/write requests to it in order, returning read data as response pulses.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (accepted when both high)
//   req_wr/req_addr/req_wdata : request: 1 = write, 0 = read; address; write data
//   pause                     : holds command issue; requests still queue
//   wr_enb/wr_addr/wr_data    : registered RAM write port
//   rd_enb/rd_addr            : registered RAM read port
//   rd_data                   : RAM read data, valid the cycle after rd_enb
//   rsp_valid/rsp_data        : read response, two cycles after rd_enb
//   init_done                 : high once the zero-fill has completed
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  pause,
    output logic                  wr_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done
);

    localparam int unsigned CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  wr_enb_q, wr_enb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_enb_q, rd_enb_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CMD_W-1:0]      fifo_head;
    logic                  head_wr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    // No pass-through when full: a pop in the same cycle does not free a slot
    // for the incoming request.
    assign req_ready = init_done_q && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign {head_wr, head_addr, head_wdata} = fifo_head;

    ram_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (fifo_push),
        .push_data_i ({req_wr, req_addr, req_wdata}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        wr_enb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_enb_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        fifo_pop    = 1'b0;
        // Read pipeline: rd_enb -> RAM data next cycle -> response register.
        rd_pend_d   = rd_enb_q;
        rsp_valid_d = rd_pend_q;
        rsp_data_d  = rd_pend_q ? rd_data : rsp_data_q;

        unique case (state_q)
            ST_INIT: begin
                wr_enb_d   = 1'b1;
                wr_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
                wr_data_d  = '0;
                init_cnt_d = init_cnt_q + CNT_ONE;
                // The extra counter bit sets once every address has been written.
                if (init_cnt_d[ADDR_WIDTH]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (!pause && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_wr) begin
                        wr_enb_d  = 1'b1;
                        wr_addr_d = head_addr;
                        wr_data_d = head_wdata;
                    end else begin
                        rd_enb_d  = 1'b1;
                        rd_addr_d = head_addr;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_enb_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            wr_enb_q    <= wr_enb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_enb_q    <= rd_enb_d;
            rd_addr_q   <= rd_addr_d;
            rd_pend_q   <= rd_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign wr_enb    = wr_enb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_enb    = rd_enb_q;
    assign rd_addr   = rd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: directed bench for ram_req_ctrl with an attached RAM, a
// queue-based reference model checked every cycle, and literal expectations
// for the zero-fill, write/read, pause, ordering and reset scenarios.
module tb_ram_req_ctrl;
    import ram_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       pause;
    logic       wr_enb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_enb;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_req_ctrl #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .pause     (pause),
        .wr_enb    (wr_enb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enb    (rd_enb),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done)
    );

    // Synchronous RAM attached to the controller; non-zero power-up contents
    // make the zero-fill observable.
    logic [7:0] ram [16] = '{default: 8'hEE};
    always @(posedge clk) begin
        if (wr_enb) ram[wr_addr] <= wr_data;
        if (rd_enb) rd_data <= ram[rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; logic [7:0] d; } rsp_t;
    cmd_t       mq[$];
    rsp_t       sched[$];
    logic [7:0] mmem [16] = '{default: 8'hEE};
    int         init_n = 0;
    int         mcyc = 0;
    bit         live = 0;
    bit         acc;
    cmd_t       mc;
    logic       e_wr_enb, e_rd_enb, e_rsp_valid, e_done, e_ready, e_is_reset;
    logic [3:0] e_wr_addr, e_rd_addr;
    logic [7:0] e_wr_data, e_rsp_data;

    always @(posedge clk) begin
        mcyc++;
        if (rst) begin
            live = 1;
            e_is_reset = 1; e_wr_enb = 0; e_rd_enb = 0; e_wr_addr = 0; e_wr_data = 0;
            e_rd_addr = 0; e_rsp_valid = 0; e_rsp_data = 0; e_done = 0; e_ready = 0;
            mq.delete(); sched.delete(); init_n = 0;
        end else begin
            e_is_reset = 0;
            acc = req_valid && e_ready;
            e_wr_enb = 0; e_rd_enb = 0;
            if (init_n < 16) begin
                e_wr_enb = 1; e_wr_addr = 4'(init_n); e_wr_data = 0;
                mmem[init_n] = 0; init_n++;
            end else begin
                e_done = 1;
                if (!pause && mq.size() > 0) begin
                    mc = mq.pop_front();
                    if (mc.wr) begin
                        e_wr_enb = 1; e_wr_addr = mc.addr; e_wr_data = mc.wdata;
                        mmem[mc.addr] = mc.wdata;
                    end else begin
                        e_rd_enb = 1; e_rd_addr = mc.addr;
                        sched.push_back('{mcyc + 2, mmem[mc.addr]});
                    end
                end
            end
            e_rsp_valid = 0;
            if (sched.size() > 0 && sched[0].cyc == mcyc) begin
                e_rsp_valid = 1; e_rsp_data = sched[0].d;
                void'(sched.pop_front());
            end
            if (acc) mq.push_back('{req_wr, req_addr, req_wdata});
            e_ready = e_done && (mq.size() < 4);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("wr_enb", wr_enb, e_wr_enb);
            chk("rd_enb", rd_enb, e_rd_enb);
            chk("req_ready", req_ready, e_ready);
            chk("init_done", init_done, e_done);
            chk("rsp_valid", rsp_valid, e_rsp_valid);
            chk("enb_exclusive", wr_enb & rd_enb, 0);
            if (e_wr_enb || e_is_reset) begin
                chk("wr_addr", wr_addr, e_wr_addr);
                chk("wr_data", wr_data, e_wr_data);
            end
            if (e_rd_enb || e_is_reset) chk("rd_addr", rd_addr, e_rd_addr);
            if (e_rsp_valid || e_is_reset) chk("rsp_data", rsp_data, e_rsp_data);
        end
    end

    // ---------------- event log for literal checks ----------------
    typedef struct { int cyc; bit wr; logic [7:0] a; logic [7:0] d; } ev_t;
    ev_t iss_q[$];
    ev_t rsp_q[$];
    int  ncyc = 0;
    int  done_cyc = -1;

    always @(negedge clk) begin
        ncyc++;
        if (wr_enb) iss_q.push_back('{ncyc, 1'b1, 8'(wr_addr), wr_data});
        if (rd_enb) iss_q.push_back('{ncyc, 1'b0, 8'(rd_addr), 8'h00});
        if (rsp_valid) rsp_q.push_back('{ncyc, 1'b0, 8'h00, rsp_data});
        if (init_done && done_cyc < 0) done_cyc = ncyc;
    end

    task automatic clear_logs();
        iss_q.delete(); rsp_q.delete(); done_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = 1; req_wr = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin step(); n++; end
        chk("push_ready", req_ready, 1);
        step();
        req_valid = 0;
    endtask

    task automatic chk_iss(input string nm, input int i, input bit w,
                           input logic [7:0] a, input logic [7:0] d);
        if (i < iss_q.size()) begin
            chk({nm, "_kind"}, iss_q[i].wr, w);
            chk({nm, "_addr"}, iss_q[i].a, a);
            if (w) chk({nm, "_data"}, iss_q[i].d, d);
        end else begin
            chk({nm, "_present"}, iss_q.size(), i + 1);
        end
    endtask

    task automatic chk_rsp(input string nm, input int i, input logic [7:0] d);
        if (i < rsp_q.size()) chk(nm, rsp_q[i].d, d);
        else chk({nm, "_present"}, rsp_q.size(), i + 1);
    endtask

    task automatic wait_init_and_check(input string nm);
        int n = 0;
        int nz = 0;
        while (!init_done && n < 40) begin step(); n++; end
        chk({nm, "_done"}, init_done, 1);
        idle(1);
        chk({nm, "_writes"}, iss_q.size(), 16);
        for (int i = 0; i < 16; i++) chk_iss(nm, i, 1'b1, 8'(i), 8'h00);
        foreach (iss_q[i]) if (iss_q[i].d != 0 || !iss_q[i].wr) nz++;
        chk({nm, "_all_zero_writes"}, nz, 0);
        if (iss_q.size() == 16) chk({nm, "_done_next_cycle"}, done_cyc - iss_q[15].cyc, 1);
        chk({nm, "_ready"}, req_ready, 1);
    endtask

    cmd_t items [5];

    initial begin
        rst = 1; req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; pause = 0;
        idle(3);
        clear_logs();
        rst = 0;
        wait_init_and_check("init");

        // Write 3 <- A5, then read 3.
        clear_logs();
        push(1, 4'h3, 8'hA5);
        push(0, 4'h3, 8'h00);
        idle(8);
        chk_iss("wr3", 0, 1'b1, 8'h03, 8'hA5);
        chk_iss("rd3", 1, 1'b0, 8'h03, 8'h00);
        if (iss_q.size() == 2) chk("rd_after_wr_gap", iss_q[1].cyc - iss_q[0].cyc, 1);
        chk("rsp3_count", rsp_q.size(), 1);
        if (rsp_q.size() == 1 && iss_q.size() == 2)
            chk("rsp3_latency", rsp_q[0].cyc - iss_q[1].cyc, 2);
        chk_rsp("rsp3_data", 0, 8'hA5);

        // Read of an address only touched by the zero-fill.
        clear_logs();
        push(0, 4'h9, 8'h00);
        idle(6);
        chk_rsp("rsp9_data", 0, 8'h00);

        // Pause while queueing five requests: only four fit.
        pause = 1;
        step();
        clear_logs();
        items = '{'{1'b1, 4'h1, 8'h11}, '{1'b1, 4'h2, 8'h22},
                  '{1'b0, 4'h1, 8'h00}, '{1'b0, 4'h2, 8'h00}, '{1'b1, 4'h4, 8'h44}};
        begin
            int accepted = 0;
            for (int i = 0; i < 5; i++) begin
                req_valid = 1; req_wr = items[i].wr; req_addr = items[i].addr;
                req_wdata = items[i].wdata;
                if (req_ready) begin accepted++; step(); end
                else idle(2);
            end
            chk("pause_accepted", accepted, 4);
        end
        chk("pause_ready_low", req_ready, 0);
        req_valid = 0;
        idle(2);
        chk("pause_no_issue", iss_q.size(), 0);
        pause = 0;
        idle(10);
        chk("pause_issue_count", iss_q.size(), 4);
        chk_iss("p0", 0, 1'b1, 8'h01, 8'h11);
        chk_iss("p1", 1, 1'b1, 8'h02, 8'h22);
        chk_iss("p2", 2, 1'b0, 8'h01, 8'h00);
        chk_iss("p3", 3, 1'b0, 8'h02, 8'h00);
        if (iss_q.size() == 4) chk("pause_back_to_back", iss_q[3].cyc - iss_q[0].cyc, 3);
        chk_rsp("p_rsp0", 0, 8'h11);
        chk_rsp("p_rsp1", 1, 8'h22);

        // Ordering across both ends of the address range.
        clear_logs();
        push(1, 4'hF, 8'h3C);
        push(1, 4'h0, 8'hC3);
        push(0, 4'hF, 8'h00);
        push(0, 4'h0, 8'h00);
        idle(8);
        chk("ord_rsp_count", rsp_q.size(), 2);
        chk_rsp("ord_rsp0", 0, 8'h3C);
        chk_rsp("ord_rsp1", 1, 8'hC3);

        // Reset with two reads in flight and a write still queued.
        pause = 1;
        push(0, 4'h5, 8'h00);
        push(0, 4'h6, 8'h00);
        push(1, 4'h7, 8'h77);
        pause = 0;
        idle(2);
        pause = 1; rst = 1;
        step();
        clear_logs();
        idle(2);
        chk("rst_no_rsp", rsp_q.size(), 0);
        chk("rst_no_issue", iss_q.size(), 0);
        chk("rst_init_done_low", init_done, 0);
        rst = 0;
        wait_init_and_check("reinit");
        pause = 0;
        idle(6);
        chk("rst_queue_flushed", iss_q.size(), 16);
        chk("rst_rsp_dropped", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_req_ctrl.md
RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width (depth 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command queue entries (power of 2).
REQ-004 SHALL have one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted at posedge when req_valid && req_ready.
REQ-009 req_wr  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  target address.
REQ-011 req_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-012 pause  in  1  holds command issue; queue keeps accepting.
REQ-013 wr_enb / wr_addr / wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  RAM write port, registered.
REQ-014 rd_enb / rd_addr  out  1 / ADDR_WIDTH  RAM read port, registered.
REQ-015 rd_data  in  DATA_WIDTH  RAM read data, valid in the cycle after rd_enb is high.
REQ-016 rsp_valid / rsp_data  out  1 / DATA_WIDTH  read response, one-cycle pulse, no backpressure.
REQ-017 init_done  out  1  high once RAM zero-fill has completed.

Function
REQ-018 FSM states ST_INIT, ST_RUN; ST_INIT entered on reset.
REQ-019 ST_INIT: one write per cycle, wr_addr 0..2**ADDR_WIDTH-1 ascending, wr_data 0, wr_enb 1; pause ignored.
REQ-020 After the last init write cycle, transition to ST_RUN; init_done goes high in the following cycle and stays high until reset.
REQ-021 req_ready = init_done && !queue_full; no same-cycle pass-through when full.
REQ-022 Accepted requests are queued in order {wr, addr, wdata}; ordering is strictly preserved.
REQ-023 ST_RUN, pause 0, queue non-empty: pop one entry per cycle; request accepted in cycle j issues in cycle j+1 at the earliest.
REQ-024 Issue drives exactly one of wr_enb or rd_enb high for one cycle with the entry's address/data; otherwise both low.
REQ-025 wr_enb and rd_enb are never high in the same cycle.
REQ-026 Read issued in cycle k: rd_data sampled at end of cycle k+1; rsp_valid high with rsp_data in cycle k+2.
REQ-027 Read following a write to the same address returns the written data (write issues first).
REQ-028 Simultaneous push and pop when not full: occupancy unchanged, both take effect.
REQ-029 pause 1: no issue; outstanding read responses still complete per REQ-026.
REQ-030 Address arithmetic in ST_INIT wraps at 2**ADDR_WIDTH; counter width ADDR_WIDTH+1 to detect completion.

Reset
REQ-031 Reset values: req_ready 0, wr_enb 0, rd_enb 0, wr_addr 0, wr_data 0, rd_addr 0, rsp_valid 0, rsp_data 0, init_done 0.
REQ-032 Reset mid-operation flushes the queue, discards in-flight read responses (no rsp_valid), and restarts ST_INIT from address 0.

Structure
REQ-033 Package ram_ctrl_pkg SHALL hold the state enum (ST_INIT, ST_RUN), the command struct typedef, and default width constants.
REQ-034 Command queue SHALL be a sub-module ram_cmd_fifo (sync FIFO, full/empty flags, sync reset).

Verification
REQ-035 Release rst -> wr_enb high 16 cycles, addr 0..15, data 0x00; init_done high in the next cycle; req_ready high.
REQ-036 Write addr 3 0xA5, then read addr 3 -> rd_enb one cycle after wr_enb; rsp_valid two cycles later, rsp_data 0xA5.
REQ-037 Read addr 9 after init only -> rsp_data 0x00.
REQ-038 pause 1, push 5 requests -> 4 accepted, req_ready low; pause 0 -> 4 commands issued in order on consecutive cycles.
REQ-039 Write 0xF 0x3C, write 0x0 0xC3, read 0xF, read 0x0 -> responses 0x3C then 0xC3.
REQ-040 Two reads outstanding, assert rst -> no rsp_valid, rd_enb 0, queue empty, init restarts at addr 0.
